// File: rtl/clock_div_prog.sv
// Programmable clock divider: clk_out toggles every `half` enabled clk cycles,
// with toggle/rise strobes and a shadowed, deferred half-period update.
module clock_div_prog #(
    parameter int unsigned CNT_W    = 26,
    parameter int unsigned DEF_HALF = 12500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             load,
    input  logic [CNT_W-1:0] half_in,
    output logic             clk_out,
    output logic             tick,
    output logic             rise,
    output logic             pend,
    output logic             err
);

    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEF_HALF);

    logic [CNT_W-1:0] cnt, half, shadow;
    logic [CNT_W-1:0] cnt_nx, half_nx, shadow_nx;
    logic             pend_nx, clk_out_nx, tick_nx, rise_nx, err_nx;

    logic [CNT_W-1:0] half_m1;
    logic             boundary;
    logic             load_ok;
    logic             load_bad;
    logic             apply_now;

    // ">=" rather than "==" so a divisor shrunk below the current count
    // resolves on the next enabled edge instead of wrapping the counter.
    assign half_m1   = half - CNT_W'(1);
    assign boundary  = (cnt >= half_m1);
    assign load_ok   = load && (half_in != '0);
    assign load_bad  = load && (half_in == '0);
    assign apply_now = pend && (sync_clr || !en || boundary);

    always_comb begin
        cnt_nx     = cnt;
        half_nx    = half;
        shadow_nx  = shadow;
        pend_nx    = pend;
        clk_out_nx = clk_out;
        tick_nx    = 1'b0;
        rise_nx    = 1'b0;
        err_nx     = err | load_bad;

        if (apply_now) begin
            half_nx = shadow;
            pend_nx = 1'b0;
        end

        // A same-edge load lands after any application, so it stays pending.
        if (load_ok) begin
            shadow_nx = half_in;
            pend_nx   = 1'b1;
        end

        if (sync_clr) begin
            cnt_nx     = '0;
            clk_out_nx = 1'b0;
            err_nx     = load_bad;
        end else if (en) begin
            if (boundary) begin
                cnt_nx     = '0;
                clk_out_nx = ~clk_out;
                tick_nx    = 1'b1;
                rise_nx    = ~clk_out;
            end else begin
                cnt_nx = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            half    <= HALF_RST;
            shadow  <= HALF_RST;
            pend    <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            rise    <= 1'b0;
            err     <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            half    <= half_nx;
            shadow  <= shadow_nx;
            pend    <= pend_nx;
            clk_out <= clk_out_nx;
            tick    <= tick_nx;
            rise    <= rise_nx;
            err     <= err_nx;
        end
    end

endmodule

// File: tb/tb_clock_div_prog.sv
// Self-checking bench for clock_div_prog (CNT_W=8, DEF_HALF=3): directed
// scenarios plus randomized traffic against a remaining-count reference model.
module tb_clock_div_prog;

    localparam int W    = 8;
    localparam int DEFH = 3;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         en       = 1'b0;
    logic         sync_clr = 1'b0;
    logic         load     = 1'b0;
    logic [W-1:0] half_in  = '0;
    logic         clk_out, tick, rise, pend, err;

    int checks   = 0;
    int failures = 0;

    // Model state: m_rem = enabled edges left until the next toggle.
    int m_rem, m_half, m_shadow;
    bit m_pend, m_clk, m_tick, m_rise, m_err;

    clock_div_prog #(.CNT_W(W), .DEF_HALF(DEFH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .load(load),
        .half_in(half_in), .clk_out(clk_out), .tick(tick), .rise(rise),
        .pend(pend), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] mv();
        return {m_clk, m_tick, m_rise, m_pend, m_err};
    endfunction

    task automatic model_reset();
        m_rem = DEFH; m_half = DEFH; m_shadow = DEFH;
        m_pend = 0; m_clk = 0; m_tick = 0; m_rise = 0; m_err = 0;
    endtask

    task automatic model_step(input bit l_en, input bit l_clr, input bit l_load, input int l_hin);
        int nh, ns;
        bit np;
        nh = m_half; ns = m_shadow; np = m_pend;
        m_tick = 0; m_rise = 0;
        if (l_clr) begin
            if (m_pend) begin nh = m_shadow; np = 0; end
            m_rem = nh; m_clk = 0; m_err = 0;
        end else if (l_en) begin
            if (m_rem <= 1) begin
                m_clk = !m_clk; m_tick = 1; m_rise = m_clk;
                if (m_pend) begin nh = m_shadow; np = 0; end
                m_rem = nh;
            end else begin
                m_rem = m_rem - 1;
            end
        end else if (m_pend) begin
            nh = m_shadow; np = 0;
            m_rem = nh - (m_half - m_rem);
        end
        if (l_load) begin
            if (l_hin != 0) begin ns = l_hin; np = 1; end
            else m_err = 1;
        end
        m_half = nh; m_shadow = ns; m_pend = np;
    endtask

    task automatic step();
        @(posedge clk);
        model_step(en, sync_clr, load, int'(half_in));
        #1;
    endtask

    // Steps until a tick is seen; n = edges taken, or -1 if the bound expires.
    task automatic wait_tick(output int n);
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (tick === 1'b1) begin n = k; break; end
        end
    endtask

    task automatic test_reset();
        int first_rise, nrise, ntick;
        first_rise = -1; nrise = 0; ntick = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({clk_out, tick, rise, pend, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", {clk_out, tick, rise, pend, err}, 5'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            step();
            checks++;
            if ({clk_out, tick, rise, pend, err} !== mv()) begin
                failures++;
                $display("FAIL run_cyc%0d got=%b exp=%b", i, {clk_out, tick, rise, pend, err}, mv());
            end
            if (tick === 1'b1) ntick++;
            if (rise === 1'b1) begin
                nrise++;
                if (first_rise < 0) first_rise = i;
            end
        end
        checks++;
        if (first_rise !== 3) begin failures++; $display("FAIL first_rise got=%0d exp=3", first_rise); end
        checks++;
        if (nrise !== 4) begin failures++; $display("FAIL rise_count got=%0d exp=4", nrise); end
        checks++;
        if (ntick !== 8) begin failures++; $display("FAIL tick_count got=%0d exp=8", ntick); end
    endtask

    task automatic test_load();
        int n;
        sync_clr = 1'b1; step(); sync_clr = 1'b0;
        step();                                  // cnt = 1
        load = 1'b1; half_in = 8'd5; step();
        load = 1'b0;
        checks++;
        if (pend !== 1'b1) begin failures++; $display("FAIL load_pend got=%b exp=1", pend); end
        wait_tick(n);
        checks++;
        if (n !== 1) begin failures++; $display("FAIL old_half_end got=%0d exp=1", n); end
        checks++;
        if (pend !== 1'b0) begin failures++; $display("FAIL pend_clear got=%b exp=0", pend); end
        for (int r = 0; r < 2; r++) begin
            wait_tick(n);
            checks++;
            if (n !== 5) begin failures++; $display("FAIL new_half%0d got=%0d exp=5", r, n); end
        end
        checks++;
        if ({clk_out, tick, rise, pend, err} !== mv()) begin
            failures++;
            $display("FAIL load_model got=%b exp=%b", {clk_out, tick, rise, pend, err}, mv());
        end
    endtask

    task automatic test_en_hold();
        logic held;
        int n;
        step(); step();                          // cnt = 2, half = 5
        en = 1'b0;
        held = clk_out;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (clk_out !== held || tick !== 1'b0 || rise !== 1'b0) begin
                failures++;
                $display("FAIL hold%0d got=%b%b%b exp=%b00", i, clk_out, tick, rise, held);
            end
        end
        en = 1'b1;
        wait_tick(n);
        checks++;
        if (n !== 3) begin failures++; $display("FAIL resume_rem got=%0d exp=3", n); end
        en = 1'b0; load = 1'b1; half_in = 8'd4; step();
        load = 1'b0;
        checks++;
        if (pend !== 1'b1) begin failures++; $display("FAIL hold_load_pend got=%b exp=1", pend); end
        step();
        checks++;
        if (pend !== 1'b0) begin failures++; $display("FAIL hold_apply got=%b exp=0", pend); end
        en = 1'b1;
        wait_tick(n);
        checks++;
        if (n !== 4) begin failures++; $display("FAIL hold_newhalf got=%0d exp=4", n); end
    endtask

    task automatic test_err();
        int n;
        load = 1'b1; half_in = 8'd0; step();
        load = 1'b0;
        checks++;
        if (err !== 1'b1 || pend !== 1'b0) begin
            failures++;
            $display("FAIL zero_load got=err%b pend%b exp=err1 pend0", err, pend);
        end
        sync_clr = 1'b1; step(); sync_clr = 1'b0;
        checks++;
        if (err !== 1'b0 || clk_out !== 1'b0 || tick !== 1'b0) begin
            failures++;
            $display("FAIL clr_err got=err%b clk%b tick%b exp=000", err, clk_out, tick);
        end
        wait_tick(n);
        checks++;
        if (n !== 4) begin failures++; $display("FAIL half_kept got=%0d exp=4", n); end
    endtask

    task automatic test_clr_apply();
        int n;
        en = 1'b0; load = 1'b1; half_in = 8'd5; step();
        load = 1'b0; sync_clr = 1'b1; step(); sync_clr = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 4; i++) step();      // half = 5, cnt = 4
        en = 1'b0; load = 1'b1; half_in = 8'd2; step();
        load = 1'b0; sync_clr = 1'b1; step(); sync_clr = 1'b0;
        checks++;
        if (pend !== 1'b0 || clk_out !== 1'b0) begin
            failures++;
            $display("FAIL clr_apply got=pend%b clk%b exp=00", pend, clk_out);
        end
        en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            wait_tick(n);
            checks++;
            if (n !== 2) begin failures++; $display("FAIL clr_half%0d got=%0d exp=2", r, n); end
        end
        en = 1'b0; load = 1'b1; half_in = 8'd1; step();
        load = 1'b0; sync_clr = 1'b1; step(); sync_clr = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (tick !== 1'b1 || clk_out !== ((i % 2) == 0)) begin
                failures++;
                $display("FAIL div2_cyc%0d got=clk%b tick%b exp=clk%0d tick1", i, clk_out, tick, (i % 2) == 0);
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        en = 1'b1; load = 1'b1; half_in = 8'd6; step();
        load = 1'b0;
        checks++;
        if (pend !== 1'b1) begin failures++; $display("FAIL pre_rst_pend got=%b exp=1", pend); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({clk_out, tick, rise, pend, err} !== 5'b0) begin
            failures++;
            $display("FAIL async_rst got=%b exp=00000", {clk_out, tick, rise, pend, err});
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n);
        checks++;
        if (n !== 3 || pend !== 1'b0) begin
            failures++;
            $display("FAIL post_rst got=n%0d pend%b exp=n3 pend0", n, pend);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            en       = ($urandom_range(0, 9) < 8);
            sync_clr = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 9) == 0);
            half_in  = ($urandom_range(0, 9) == 0) ? 8'd0 : W'($urandom_range(1, 7));
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step();
            checks++;
            if ({clk_out, tick, rise, pend, err} !== mv()) begin
                failures++;
                $display("FAIL rand_cyc%0d got=%b exp=%b", i, {clk_out, tick, rise, pend, err}, mv());
            end
        end
        en = 1'b0; sync_clr = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_en_hold();
        test_err();
        test_clr_apply();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_div_prog.md
CLOCK_DIV_PROG -- requirements
Module: clock_div_prog

Interface
REQ-001 The block SHALL have parameter CNT_W, default 26, giving the width of the half-period counter and divisor.
REQ-002 The block SHALL have parameter DEF_HALF, default 12500000, giving the reset half-period in clk cycles (4 Hz output from 100 MHz).
REQ-003 Port: clk  input  1  system clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: en  input  1  count enable; when low, counter and outputs hold.
REQ-006 Port: sync_clr  input  1  synchronous restart of the output phase.
REQ-007 Port: load  input  1  single-cycle request to change the half-period.
REQ-008 Port: half_in  input  CNT_W  requested half-period in clk cycles, sampled when load=1.
REQ-009 Port: clk_out  output  1  divided clock, registered.
REQ-010 Port: tick  output  1  one-cycle strobe coincident with every clk_out toggle.
REQ-011 Port: rise  output  1  one-cycle strobe coincident with every 0->1 toggle of clk_out.
REQ-012 Port: pend  output  1  a loaded half-period is waiting to be applied.
REQ-013 Port: err  output  1  sticky flag: a load with half_in=0 was rejected.

Function
REQ-014 Registers SHALL be: cnt (CNT_W), half (CNT_W, active divisor), shadow (CNT_W), pend, clk_out, tick, rise, err.
REQ-015 With en=1 and cnt != half-1, cnt SHALL increment by 1 and tick and rise SHALL be 0.
REQ-016 With en=1 and cnt == half-1 (the boundary), on that edge cnt SHALL become 0, clk_out SHALL invert, tick SHALL be 1, and rise SHALL equal the new clk_out.
REQ-017 At a boundary with pend=1, half SHALL take shadow and pend SHALL clear on the same edge; the period just completed uses the old half.
REQ-018 With en=0, cnt and clk_out SHALL hold, and tick and rise SHALL be 0.
REQ-019 With en=0 and pend=1, half SHALL take shadow and pend SHALL clear on the next edge.
REQ-020 When sync_clr=1, regardless of en, the next edge SHALL set cnt=0, clk_out=0, tick=0, rise=0 and err=0.
REQ-021 When sync_clr=1 and pend=1, the same edge SHALL apply shadow to half and clear pend.
REQ-022 sync_clr SHALL take priority over the boundary action and over en.
REQ-023 load=1 with half_in != 0 SHALL write half_in to shadow and set pend on the next edge.
REQ-024 A new load while pend=1 SHALL overwrite shadow (last writer wins).
REQ-025 load=1 with half_in == 0 SHALL leave shadow and pend unchanged and SHALL set err.
REQ-026 When load and a boundary occur on the same edge, the boundary SHALL apply the old shadow if pend was already set. The new half_in SHALL then go to shadow with pend=1.
REQ-027 When load and sync_clr occur on the same edge, the old pending value (if any) SHALL be applied and the new half_in SHALL become pending. err SHALL clear unless half_in=0, in which case err=1.
REQ-028 half=1 SHALL make clk_out toggle every enabled cycle (clk/2), with tick held high.
REQ-029 Counter comparison SHALL be unsigned CNT_W-bit.
REQ-030 cnt SHALL never exceed half-1 after an applied change: if cnt >= new half-1 at application time, the next enabled edge SHALL be treated as a boundary.
REQ-031 The output period SHALL be 2*half enabled cycles, and rise SHALL occur once per period.

Reset
REQ-032 On rst_n=0, asynchronously: cnt=0, half=DEF_HALF, shadow=DEF_HALF, pend=0, clk_out=0, tick=0, rise=0, err=0.
REQ-033 Release of rst_n SHALL be followed by normal counting from the first rising edge where rst_n=1.
REQ-034 Reset asserted mid-period or with pend=1 SHALL discard the pending value.

Verification (bench uses CNT_W=8, DEF_HALF=3)
REQ-035 Reset release, en=1 held, 24 cycles -> clk_out toggles every 3 cycles (period 6); tick on each toggle; rise every 6 cycles, first rise 3 cycles after release.
REQ-036 load with half_in=5 when cnt=1 -> pend=1; the current half-period still ends after 3 counts, then half-periods are 5 cycles; pend clears at that boundary.
REQ-037 en=0 for 4 cycles mid-period -> cnt and clk_out frozen, no tick; the period resumes with the remaining counts. load during en=0 is applied on the following edge.
REQ-038 load half_in=0 -> err=1, half unchanged, pend unchanged; then sync_clr -> err=0, cnt=0, clk_out=0.
REQ-039 half=5 and cnt=4, then load half_in=2 applied via sync_clr -> next half-period is 2 cycles. Separately, with half=1: clk_out = clk/2 and tick constant 1.
REQ-040 rst_n pulsed low mid-cycle with pend=1 -> all outputs 0 immediately (no clock needed), half=3 after release, pend=0.
